// File: rtl/mdu_seq_pkg.sv
// mdu_seq_pkg: MDU command encodings and default latencies shared by the
// multiply/divide sequencer, the E-stage controller and the hazard unit.
package mdu_seq_pkg;

    typedef enum logic [2:0] {
        MDU_NONE  = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MTHI  = 3'd5,
        MDU_MTLO  = 3'd6,
        MDU_RSVD  = 3'd7
    } mdu_op_e;

    localparam int MDU_MULT_CYCLES_DEF = 5;
    localparam int MDU_DIV_CYCLES_DEF  = 10;

    // Ops that occupy the unit for a multi-cycle busy window.
    function automatic logic is_arith_op(mdu_op_e op);
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_DIV)  || (op == MDU_DIVU);
    endfunction

    function automatic logic is_div_op(mdu_op_e op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: purely combinational multiply/divide result generator.
// Ports:
//   op_i    MDU command (only mult/multu/div/divu produce a result)
//   a_i     operand rs
//   b_i     operand rt
//   res_o   {HI, LO}: product, or {remainder, quotient}
//   div0_o  high for div/divu with a zero divisor
module mdu_arith
    import mdu_seq_pkg::*;
(
    input  logic [2:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [63:0] res_o,
    output logic        div0_o
);

    mdu_op_e            op;
    logic signed [63:0] a_sx, b_sx, prod_s;
    logic        [63:0] prod_u;
    logic        [31:0] b_safe, q_u, r_u;
    logic signed [31:0] a_s, b_s, q_s, r_s;
    logic               s_ovf;

    assign op = mdu_op_e'(op_i);

    always_comb begin
        div0_o = is_div_op(op) && (b_i == 32'd0);

        a_sx   = {{32{a_i[31]}}, a_i};
        b_sx   = {{32{b_i[31]}}, b_i};
        prod_s = a_sx * b_sx;
        prod_u = {32'd0, a_i} * {32'd0, b_i};

        // A zero divisor is replaced so the divider never produces X;
        // the result is discarded by the sequencer anyway.
        b_safe = (b_i == 32'd0) ? 32'd1 : b_i;
        q_u    = a_i / b_safe;
        r_u    = a_i % b_safe;

        a_s    = a_i;
        b_s    = b_safe;
        // The one signed quotient that does not fit: wrap to 0x80000000, rem 0.
        s_ovf  = (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF);
        if (s_ovf) begin
            q_s = a_s;
            r_s = 32'sd0;
        end else begin
            q_s = a_s / b_s;
            r_s = a_s % b_s;
        end

        case (op)
            MDU_MULT:  res_o = prod_s;
            MDU_MULTU: res_o = prod_u;
            MDU_DIV:   res_o = {r_s, q_s};
            MDU_DIVU:  res_o = {r_u, q_u};
            default:   res_o = 64'd0;
        endcase
    end

endmodule

// File: rtl/mdu_seq.sv
// mdu_seq: multi-cycle multiply/divide sequencer with HI/LO registers.
// The result is computed when the command is accepted and held in pending
// registers; HI/LO are updated on the edge that ends the busy window.
// Ports:
//   clk, reset   rising-edge clock, asynchronous active-high reset
//   MDUen        command valid in E
//   MDUop        command (see mdu_op_e)
//   SRCA, SRCB   operands (SRCA is also the mthi/mtlo data)
//   busy         registered, high while an operation is in flight
//   start        combinational, an arithmetic command is accepted this cycle
//   HI, LO       architectural HI/LO registers
module mdu_seq
    import mdu_seq_pkg::*;
#(
    parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MDUen,
    input  logic [2:0]  MDUop,
    input  logic [31:0] SRCA,
    input  logic [31:0] SRCB,
    output logic        busy,
    output logic        start,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic {IDLE, RUN} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic               pend_wr_q, pend_wr_d;
    logic [31:0]        hi_q, hi_d, lo_q, lo_d;

    mdu_op_e            op;
    logic [63:0]        arith_res;
    logic               arith_div0;

    assign op = mdu_op_e'(MDUop);

    mdu_arith u_arith (
        .op_i   (MDUop),
        .a_i    (SRCA),
        .b_i    (SRCB),
        .res_o  (arith_res),
        .div0_o (arith_div0)
    );

    assign busy  = (state_q == RUN);
    assign start = MDUen && is_arith_op(op) && (state_q == IDLE);
    assign HI    = hi_q;
    assign LO    = lo_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    {pend_hi_d, pend_lo_d} = arith_res;
                    // Divide by zero still burns the window but never writes.
                    pend_wr_d = !arith_div0;
                    cnt_d     = is_div_op(op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                    state_d   = RUN;
                end else if (MDUen && (op == MDU_MTHI)) begin
                    hi_d = SRCA;
                end else if (MDUen && (op == MDU_MTLO)) begin
                    lo_d = SRCA;
                end
            end
            RUN: begin
                // Commands arriving now are ignored; the hazard unit stalls them.
                if (cnt_q == CNT_W'(1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    if (pend_wr_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_wr_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

endmodule

// File: tb/tb_mdu_seq.sv
module tb_mdu_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        MDUen;
    logic [2:0]  MDUop;
    logic [31:0] SRCA, SRCB;
    logic        busy, start;
    logic [31:0] HI, LO;

    int checks   = 0;
    int failures = 0;

    // Reference state: architectural HI/LO, pending result, cycles left busy.
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0, m_phi = 32'd0, m_plo = 32'd0;
    bit          m_pwr = 1'b0;
    int          m_rem = 0;

    mdu_seq dut (
        .clk   (clk),
        .reset (reset),
        .MDUen (MDUen),
        .MDUop (MDUop),
        .SRCA  (SRCA),
        .SRCB  (SRCB),
        .busy  (busy),
        .start (start),
        .HI    (HI),
        .LO    (LO)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    // Result from arithmetic on 64-bit integers: quotient is |a|/|b| with
    // the sign fixed up afterwards, remainder is a - q*b.
    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b, output bit wr);
        longint la, lb, qa, q, r, p;
        bit     sgn;
        sgn = (op == 3'd1) || (op == 3'd3);
        la  = sgn ? longint'($signed(a)) : longint'({32'd0, a});
        lb  = sgn ? longint'($signed(b)) : longint'({32'd0, b});
        wr  = 1'b1;
        if (op <= 3'd2) begin
            p = la * lb;
            return p;
        end
        if (b == 32'd0) begin
            wr = 1'b0;
            return 64'd0;
        end
        qa = (la < 0 ? -la : la) / (lb < 0 ? -lb : lb);
        q  = ((la < 0) != (lb < 0)) ? -qa : qa;
        r  = la - q * lb;
        return {r[31:0], q[31:0]};
    endfunction

    // One clock: drive inputs, check start, advance the model, check outputs.
    task automatic step(input bit en, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bit          es, wr;
        logic [63:0] res;
        MDUen = en; MDUop = op; SRCA = a; SRCB = b;
        #1;
        es = en && (op >= 3'd1) && (op <= 3'd4) && (m_rem == 0);
        check("start", 32'(start), 32'(es));
        if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0 && m_pwr) begin
                m_hi = m_phi;
                m_lo = m_plo;
            end
        end else if (es) begin
            res = ref_result(op, a, b, wr);
            {m_phi, m_plo} = res;
            m_pwr = wr;
            m_rem = (op <= 3'd2) ? 5 : 10;
        end else if (en && op == 3'd5) begin
            m_hi = a;
        end else if (en && op == 3'd6) begin
            m_lo = a;
        end
        @(posedge clk);
        #1;
        check("busy", 32'(busy), 32'(m_rem > 0));
        check("HI", HI, m_hi);
        check("LO", LO, m_lo);
    endtask

    // Issue one arithmetic op and idle until busy drops; returns busy length.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int cyc);
        step(1'b1, op, a, b);
        cyc = busy ? 1 : 0;
        for (int i = 0; i < 40 && busy; i++) begin
            step(1'b0, 3'd0, 32'd0, 32'd0);
            if (busy) cyc++;
        end
        check("busy_timeout", 32'(busy), 32'd0);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && busy; i++) step(1'b0, 3'd0, 32'd0, 32'd0);
        check("drain_timeout", 32'(busy), 32'd0);
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int cyc;
        reset = 1'b0; MDUen = 1'b0; MDUop = 3'd0; SRCA = 32'd0; SRCB = 32'd0;
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_HI", HI, 32'd0);
        check("rst_LO", LO, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) step(1'b0, 3'd0, 32'h1234, 32'h5678);

        run_op(3'd1, 32'd3, 32'hFFFF_FFFC, cyc);
        check("mult_cycles", 32'(cyc), 32'd5);
        check("mult_HI", HI, 32'hFFFF_FFFF);
        check("mult_LO", LO, 32'hFFFF_FFF4);

        run_op(3'd2, 32'd3, 32'hFFFF_FFFC, cyc);
        check("multu_HI", HI, 32'h0000_0002);
        check("multu_LO", LO, 32'hFFFF_FFF4);

        run_op(3'd3, 32'hFFFF_FFF9, 32'd2, cyc);
        check("div_cycles", 32'(cyc), 32'd10);
        check("div_LO", LO, 32'hFFFF_FFFD);
        check("div_HI", HI, 32'hFFFF_FFFF);

        step(1'b1, 3'd5, 32'h11, 32'd0);
        step(1'b1, 3'd6, 32'h22, 32'd0);
        run_op(3'd4, 32'd7, 32'd0, cyc);
        check("div0_cycles", 32'(cyc), 32'd10);
        check("div0_HI", HI, 32'h11);
        check("div0_LO", LO, 32'h22);

        // mthi/mtlo while busy are dropped.
        step(1'b1, 3'd1, 32'd5, 32'd6);
        for (int i = 0; i < 40 && busy; i++) begin
            step(1'b1, (i % 2 == 0) ? 3'd5 : 3'd6, 32'hDEAD_BEEF, 32'd0);
        end
        check("ign_HI", HI, 32'd0);
        check("ign_LO", LO, 32'd30);
        step(1'b1, 3'd5, 32'hDEAD_BEEF, 32'd0);
        check("mthi_HI", HI, 32'hDEAD_BEEF);
        check("mthi_busy", 32'(busy), 32'd0);
        step(1'b1, 3'd6, 32'hCAFE_F00D, 32'd0);
        check("mtlo_LO", LO, 32'hCAFE_F00D);

        // Back-to-back mult held on MDUen.
        step(1'b1, 3'd1, 32'd7, 32'd9);
        for (int i = 0; i < 40 && busy; i++) step(1'b1, 3'd1, 32'd7, 32'd9);
        check("b2b_LO", LO, 32'd63);
        #1;
        check("b2b_start", 32'(start), 32'd1);
        step(1'b1, 3'd1, 32'd7, 32'd9);
        check("b2b_busy", 32'(busy), 32'd1);
        drain();

        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
        check("ovf_LO", LO, 32'h8000_0000);
        check("ovf_HI", HI, 32'd0);

        // Reset during the third busy cycle of a div.
        step(1'b1, 3'd3, 32'd100, 32'd7);
        step(1'b0, 3'd0, 32'd0, 32'd0);
        step(1'b0, 3'd0, 32'd0, 32'd0);
        #1 reset = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_HI", HI, 32'd0);
        check("arst_LO", LO, 32'd0);
        m_rem = 0; m_hi = 32'd0; m_lo = 32'd0; m_pwr = 1'b0;
        #1 reset = 1'b0;
        for (int i = 0; i < 15; i++) step(1'b0, 3'd0, 32'd0, 32'd0);
        check("arst_late_HI", HI, 32'd0);
        check("arst_late_LO", LO, 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), rnd_operand(), rnd_operand());
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
Multi-cycle multiply/divide sequencer with HI/LO registers, sitting in the E stage beside the ALU. It accepts mult/multu/div/divu/mthi/mtlo commands from the E-stage control and models fixed execution latency with a busy counter. It exports busy status so the hazard unit can stall mfhi/mflo and further MDU instructions in D. HI/LO are read combinationally by the E-stage forwarding mux.

Parameters:
MULT_CYCLES, 5, cycles busy is held for mult/multu (>=1)
DIV_CYCLES, 10, cycles busy is held for div/divu (>=1)
CNT_W, 4, counter width; must hold max(MULT_CYCLES, DIV_CYCLES)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
MDUen  in  1  command valid this cycle (E stage holds an MDU instruction)
MDUop  in  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
SRCA  in  32  operand rs (also mthi/mtlo data)
SRCB  in  32  operand rt
busy  out  1  registered; high while an operation is in flight
start  out  1  combinational; MDUen & MDUop in 1..4 & !busy
HI  out  32  registered HI
LO  out  32  registered LO

Behaviour:
- Reset (asynchronous, immediate): state IDLE, counter 0, busy 0, HI 0, LO 0, pending result cleared. Reset mid-operation aborts; no HI/LO write occurs afterward.
- FSM states: IDLE, RUN.
- IDLE + accepted start at edge T0: compute the result combinationally from SRCA/SRCB and latch it into pend_hi/pend_lo; load counter = MULT_CYCLES or DIV_CYCLES; go to RUN; busy=1 from T0.
- RUN: counter decrements each edge. At the edge where counter==1: HI/LO <= pending values, busy <= 0, go to IDLE. busy is therefore high for exactly N cycles, and new HI/LO are visible in the same cycle busy falls.
- mult: signed 32x32 -> 64; HI=[63:32], LO=[31:0]. multu: unsigned.
- div: signed; LO=quotient truncated toward zero, HI=remainder with the sign of the dividend. divu: unsigned.
- Divide by zero (SRCB==0): the operation still runs the full DIV_CYCLES busy window, but HI/LO are left unchanged at completion.
- Signed overflow (0x80000000 / -1): LO=0x80000000, HI=0; no trap.
- mthi/mtlo (op 5/6) with MDUen in IDLE: HI (or LO) <= SRCA at the next edge; busy stays 0; single cycle.
- Any MDUen command while busy=1 is ignored: no restart, no HI/LO write. The hazard unit must stall upstream; the block does not queue.
- On the completion edge, a new start in the same cycle is not possible (busy still 1); it is accepted on the following edge.
- Op 0/7 and MDUen=0: no effect.

Decomposition:
- Shared package/header: MDUop encodings (MDU_NONE..MDU_MTLO) and default latencies, shared with the controller and hazard unit.
- One natural sub-module, mdu_arith: purely combinational 64-bit result for op/SRCA/SRCB, plus a div0 flag. The sequencer holds the FSM, counter, pending registers and HI/LO.

Test Plan:
- Reset then idle: HI=LO=0, busy=0; MDUen=0 for 5 cycles -> no change.
- mult SRCA=3, SRCB=0xFFFFFFFC: start=1, busy high exactly 5 cycles; at busy fall HI=0xFFFFFFFF, LO=0xFFFFFFF4. multu same operands -> HI=0x00000002, LO=0xFFFFFFF4.
- div SRCA=0xFFFFFFF9 (-7), SRCB=2: busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 7/0 after HI=0x11, LO=0x22 -> busy 10 cycles, HI/LO stay 0x11/0x22.
- mthi 0xDEADBEEF issued while a mult is busy -> ignored. After completion, mthi 0xDEADBEEF -> HI=0xDEADBEEF the next cycle with busy=0. mtlo behaves likewise.
- Back-to-back: mult held on MDUen continuously -> second start accepted exactly one cycle after busy falls. div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- Reset asserted in cycle 3 of a div -> busy, HI and LO go to 0 immediately; after release, no late HI/LO write occurs.
